// File: rtl/izh_spike_decoder_if.sv
// Sample stream into the spike decoder and FWFT ISI stream out of it.
// Decoder side uses the slave modport; the sample source / ISI consumer uses master.
interface izh_spike_decoder_if #(
    parameter int TW = 16
);
    logic              sample_en;
    logic signed [7:0] v_in;
    logic              isi_valid;
    logic [TW-1:0]     isi_data;
    logic              isi_ready;

    modport master (
        output sample_en, v_in, isi_ready,
        input  isi_valid, isi_data
    );

    modport slave (
        input  sample_en, v_in, isi_ready,
        output isi_valid, isi_data
    );
endinterface

// File: rtl/izh_spike_decoder.sv
// Threshold/hysteresis spike detector with ISI measurement, saturating spike count and FWFT ISI FIFO.
// spike_pulse one cycle after the spike sample; ISIs dropped (sticky overflow) only when full with no pop.
module izh_spike_decoder #(
    parameter int TW    = 16,
    parameter int DEPTH = 4,
    parameter int HYST  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic signed [7:0]      thresh,
    izh_spike_decoder_if.slave     isi_if,
    output logic                   spike_pulse,
    output logic                   overflow,
    output logic [7:0]             spike_count
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);
    localparam logic [8:0]    HYST9    = 9'(HYST);

    typedef enum logic {ARMED, FIRED} state_t;

    state_t        state_q, state_d;
    logic          first_q, first_d;
    logic [TW-1:0] isi_cnt_q, isi_cnt_d;
    logic [7:0]    spike_count_q, spike_count_d;
    logic          pulse_q, pulse_d;
    logic          overflow_q, overflow_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] mem_q [DEPTH];

    logic signed [8:0] v_ext;
    logic signed [8:0] rearm_lim;
    logic [AW:0]       fill;
    logic              fifo_full;
    logic              fifo_vld;
    logic              spike;
    logic              pop;
    logic              push;
    logic              wr_en;
    logic              drop;

    // 9-bit arithmetic so thresh - HYST cannot wrap around to a large positive limit.
    assign v_ext     = {isi_if.v_in[7], isi_if.v_in};
    assign rearm_lim = $signed({thresh[7], thresh}) - $signed(HYST9);

    assign fill      = wr_ptr_q - rd_ptr_q;
    assign fifo_full = (fill == FULL_LVL);
    assign fifo_vld  = (fill != '0);

    assign spike = isi_if.sample_en && (state_q == ARMED) && ($signed(isi_if.v_in) > thresh);
    assign pop   = fifo_vld && isi_if.isi_ready;
    assign push  = spike && !first_q;
    assign wr_en = push && (!fifo_full || pop);
    assign drop  = push && fifo_full && !pop;

    always_comb begin
        state_d       = state_q;
        first_d       = first_q;
        isi_cnt_d     = isi_cnt_q;
        spike_count_d = spike_count_q;
        pulse_d       = spike;
        overflow_d    = overflow_q | drop;
        wr_ptr_d      = wr_ptr_q + (wr_en ? PTR_ONE : '0);
        rd_ptr_d      = rd_ptr_q + (pop ? PTR_ONE : '0);
        if (isi_if.sample_en) begin
            case (state_q)
                ARMED:   if (spike) state_d = FIRED;
                FIRED:   if (v_ext < rearm_lim) state_d = ARMED;
                default: state_d = ARMED;
            endcase
            if (spike) begin
                first_d   = 1'b0;
                isi_cnt_d = CNT_ONE;
                if (spike_count_q != 8'hFF) spike_count_d = spike_count_q + 8'd1;
            end else if (isi_cnt_q != '1) begin
                isi_cnt_d = isi_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q       <= ARMED;
            first_q       <= 1'b1;
            isi_cnt_q     <= '0;
            spike_count_q <= '0;
            pulse_q       <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            first_q       <= first_d;
            isi_cnt_q     <= isi_cnt_d;
            spike_count_q <= spike_count_d;
            pulse_q       <= pulse_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= isi_cnt_q;
    end

    assign isi_if.isi_valid = fifo_vld;
    assign isi_if.isi_data  = fifo_vld ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign spike_pulse      = pulse_q;
    assign overflow         = overflow_q;
    assign spike_count      = spike_count_q;
endmodule

// File: tb/tb_izh_spike_decoder.sv
// Directed bench for izh_spike_decoder: a TW=16 instance and a TW=4 instance share one stimulus.
module tb_izh_spike_decoder;
    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              clear  = 1'b0;
    logic signed [7:0] thresh = 8'sd20;
    logic              s_en   = 1'b0;
    logic signed [7:0] v      = 8'sd0;
    logic              rdy    = 1'b0;

    int checks   = 0;
    int failures = 0;

    izh_spike_decoder_if #(.TW(16)) a_if ();
    izh_spike_decoder_if #(.TW(4))  b_if ();

    assign a_if.sample_en = s_en;
    assign a_if.v_in      = v;
    assign a_if.isi_ready = rdy;
    assign b_if.sample_en = s_en;
    assign b_if.v_in      = v;
    assign b_if.isi_ready = rdy;

    logic       a_pulse, a_ovf, b_pulse, b_ovf;
    logic [7:0] a_cnt, b_cnt;

    izh_spike_decoder #(.TW(16), .DEPTH(4), .HYST(8)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .thresh      (thresh),
        .isi_if      (a_if.slave),
        .spike_pulse (a_pulse),
        .overflow    (a_ovf),
        .spike_count (a_cnt)
    );

    izh_spike_decoder #(.TW(4), .DEPTH(4), .HYST(8)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .thresh      (thresh),
        .isi_if      (b_if.slave),
        .spike_pulse (b_pulse),
        .overflow    (b_ovf),
        .spike_count (b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input int val);
        s_en = en;
        v    = 8'(val);
        @(posedge clk);
        #1;
    endtask

    // n sub-threshold samples then one spike sample: pushed ISI is n+1.
    task automatic gap_spike(input int n);
        repeat (n) step(1'b1, 0);
        step(1'b1, 30);
    endtask

    initial begin
        // Reset overrides a spiking input.
        step(1'b1, 100);
        step(1'b1, 100);
        chk("rst_pulse", 32'(a_pulse), 0);
        chk("rst_valid", 32'(a_if.isi_valid), 0);
        chk("rst_data", 32'(a_if.isi_data), 0);
        chk("rst_ovf", 32'(a_ovf), 0);
        chk("rst_cnt", 32'(a_cnt), 0);
        rst_n = 1'b1;

        // First spike: no ISI pushed.
        repeat (5) step(1'b1, -40);
        chk("pre_spike_pulse", 32'(a_pulse), 0);
        step(1'b1, 30);
        chk("first_pulse", 32'(a_pulse), 1);
        chk("first_cnt", 32'(a_cnt), 1);
        chk("first_valid", 32'(a_if.isi_valid), 0);
        step(1'b1, 0);
        chk("first_pulse_off", 32'(a_pulse), 0);

        // Spike 15 samples later.
        repeat (13) step(1'b1, 0);
        step(1'b1, 30);
        chk("isi_valid", 32'(a_if.isi_valid), 1);
        chk("isi_15", 32'(a_if.isi_data), 15);
        chk("isi_pulse", 32'(a_pulse), 1);
        chk("isi_cnt", 32'(a_cnt), 2);
        rdy = 1'b1;
        step(1'b1, 0);
        rdy = 1'b0;
        chk("pop_empty", 32'(a_if.isi_valid), 0);

        // Hysteresis: no re-arm until v_in < 12.
        step(1'b1, 30);
        chk("hyst_first_isi", 32'(a_if.isi_data), 2);
        chk("hyst_first_cnt", 32'(a_cnt), 3);
        repeat (3) step(1'b1, 15);
        repeat (3) step(1'b1, 30);
        chk("hyst_hold_pulse", 32'(a_pulse), 0);
        chk("hyst_hold_cnt", 32'(a_cnt), 3);
        step(1'b1, 12);
        step(1'b1, 30);
        chk("hyst_at_lim_pulse", 32'(a_pulse), 0);
        step(1'b1, 11);
        step(1'b1, 30);
        chk("hyst_rearm_pulse", 32'(a_pulse), 1);
        chk("hyst_rearm_cnt", 32'(a_cnt), 4);
        chk("fifo_head_2", 32'(a_if.isi_data), 2);
        rdy = 1'b1;
        step(1'b0, 0);
        chk("fifo_head_10", 32'(a_if.isi_data), 10);
        step(1'b0, 0);
        rdy = 1'b0;
        chk("fifo_drained", 32'(a_if.isi_valid), 0);

        // Gated clocks carry a spiking voltage and must be ignored.
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 0);
            if (i < 7) begin
                step(1'b0, 100);
                chk("gated_pulse", 32'(a_pulse), 0);
            end
        end
        chk("gated_cnt", 32'(a_cnt), 4);
        step(1'b1, 30);
        chk("gated_isi_15", 32'(a_if.isi_data), 15);
        chk("gated_spike_cnt", 32'(a_cnt), 5);
        rdy = 1'b1;
        step(1'b1, 0);
        rdy = 1'b0;
        chk("gated_drained", 32'(a_if.isi_valid), 0);

        // Fill with ISIs 4,5,6,7; ISI 8 dropped.
        gap_spike(2);
        gap_spike(4);
        gap_spike(5);
        gap_spike(6);
        chk("full_no_ovf", 32'(a_ovf), 0);
        chk("full_head", 32'(a_if.isi_data), 4);
        gap_spike(7);
        chk("drop_ovf", 32'(a_ovf), 1);
        chk("drop_head", 32'(a_if.isi_data), 4);
        chk("drop_cnt", 32'(a_cnt), 10);
        repeat (8) step(1'b1, 0);
        rdy = 1'b1;
        step(1'b1, 30);
        rdy = 1'b0;
        chk("full_pushpop_head", 32'(a_if.isi_data), 5);
        chk("full_pushpop_ovf", 32'(a_ovf), 1);
        chk("full_pushpop_cnt", 32'(a_cnt), 11);
        rdy = 1'b1;
        step(1'b0, 0);
        rdy = 1'b0;
        chk("after_pop_head", 32'(a_if.isi_data), 6);

        // Clear with 3 entries, overflow set and FSM fired.
        clear = 1'b1;
        step(1'b1, 30);
        clear = 1'b0;
        chk("clr_valid", 32'(a_if.isi_valid), 0);
        chk("clr_data", 32'(a_if.isi_data), 0);
        chk("clr_ovf", 32'(a_ovf), 0);
        chk("clr_cnt", 32'(a_cnt), 0);
        chk("clr_pulse", 32'(a_pulse), 0);
        step(1'b1, 30);
        chk("clr_rearm_pulse", 32'(a_pulse), 1);
        chk("clr_rearm_cnt", 32'(a_cnt), 1);
        chk("clr_first_nopush", 32'(a_if.isi_valid), 0);
        step(1'b1, 30);
        chk("clr_fired_pulse", 32'(a_pulse), 0);

        // Saturation of ISI (TW=4) and spike count.
        rst_n = 1'b0;
        step(1'b1, 0);
        rst_n = 1'b1;
        step(1'b1, 30);
        repeat (19) step(1'b1, 0);
        step(1'b1, 30);
        chk("sat_isi_tw4", 32'(b_if.isi_data), 15);
        chk("sat_valid_tw4", 32'(b_if.isi_valid), 1);
        chk("isi_20_tw16", 32'(a_if.isi_data), 20);
        chk("sat_cnt_tw4", 32'(b_cnt), 2);
        repeat (252) begin
            step(1'b1, 0);
            step(1'b1, 30);
        end
        chk("cnt_254", 32'(a_cnt), 254);
        step(1'b1, 0);
        step(1'b1, 30);
        chk("cnt_255", 32'(a_cnt), 255);
        repeat (45) begin
            step(1'b1, 0);
            step(1'b1, 30);
        end
        chk("cnt_sat_a", 32'(a_cnt), 255);
        chk("cnt_sat_b", 32'(b_cnt), 255);
        chk("sat_pulse", 32'(a_pulse), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
